status_ctl: RTL and testbench
=============================

# status_ctl

Parametrised status-and-carry control unit for the micro-BESM datapath: holds the micro status register (uSR) and machine status register (MSR), evaluates branch conditions for the sequencer, generates ALU carry-in, and adds a DEPTH-entry hardware save stack for {MSR,uSR} used on interrupt entry/return. It sits beside the ALU slices; flags arrive from the ALU each cycle, CT goes to the microsequencer, and co goes to the ALU carry input.

## Interface
- DEPTH, 4: save-stack entries (≥1).
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- op  in  4  status operation (status_pkg::op_t).
- fl_en  in  4  per-flag MSR write enable {ovr,n,c,z}, applies to MSR load ops.
- alu_f  in  4  ALU flags {ovr,n,c,z}.
- bus_f  in  4  flags from Y bus, for BUS_TO_M.
- bit_sel  in  2  flag index for SET_UBIT/CLR_UBIT.
- sh_c_en  in  1  shift-carry override strobe.
- sh_c  in  1  bit shifted out, written to MSR.c when sh_c_en.
- cond  in  6  [5:4] source (0 uSR, 1 MSR, 2 alu_f, 3 constant), [3:0] test.
- cin_sel  in  2  0 → 0, 1 → 1, 2 → cx, 3 → carry flag of cond[5:4] source (uSR if source 0, else MSR).
- cin_inv  in  1  invert co.
- cx  in  1  external carry.
- clr_err  in  1  clear err.
- usr  out  4  uSR.
- msr  out  4  MSR.
- ct  out  1  condition test result.
- co  out  1  ALU carry-in.
- depth  out  $clog2(DEPTH+1)  stack occupancy.
- full, empty, err  out  1 each.

## Operation
- Flag order everywhere {ovr,n,c,z}, bit 3..0.
- op codes: 0 NOP; 1 LOAD_U uSR←alu_f; 2 LOAD_M MSR←alu_f (masked); 3 LOAD_BOTH; 4 LOAD_M_CINV MSR←alu_f with c inverted (masked); 5 LOAD_M_VRET MSR.ovr←ovr|MSR.ovr, others from alu_f (masked); 6 SWAP uSR↔MSR; 7 M_TO_U; 8 BUS_TO_M (masked); 9 SET_M 1111; 10 CLR_M 0000; 11 INV_M ~MSR (masked); 12 PUSH; 13 POP; 14 SET_UBIT; 15 CLR_UBIT.
- fl_en masks ops 2,4,5,8,11 only; SWAP, SET_M, CLR_M, POP write all four bits.
- sh_c_en overrides any op's write of MSR.c in the same cycle; other MSR bits follow op.
- PUSH: stores {MSR,uSR} as current before-edge values; depth+1. Full → no write, depth unchanged, err←1.
- POP: restores MSR,uSR from top entry; depth−1. Empty → no register change, err←1.
- err sticky until clr_err; clr_err with a new error in same cycle → err=1.
- ct tests: 0 (n^ovr)|z, 2 n^ovr, 4 z, 6 ovr, 8 c|z, 10 c, 12 ~c|z, 14 n; odd code = complement of code−1. Source 3: ct = ~cond[0].
- co = (cin_sel mux) ^ cin_inv.

## Timing
- Reset: usr=0, msr=0, depth=0, empty=1, full=0, err=0; stack contents don't-care.
- Register/stack effects visible one cycle after op edge; popped values on usr/msr next cycle.
- ct, co purely combinational from current registers and inputs, zero latency.
- full = (depth==DEPTH), empty = (depth==0), both registered-state derived.
- reset mid-sequence: stack emptied immediately, no partial restore.

## Structure
- status_pkg: op_t enum, flag index constants (F_Z=0,F_C=1,F_N=2,F_OVR=3), flags_t 4-bit type, cond source constants.
- Sub-module status_stack: DEPTH×8 LIFO with push/pop/full/empty/overflow-underflow strobes; status_ctl owns registers, masking, ct and co logic.

## Test plan
- Reset then idle → usr=0, msr=0, depth=0, empty=1, ct for cond=6'b01_0101 (~MZ) =1.
- LOAD_M alu_f=1010, fl_en=0011 from msr=0101 → msr=0110 next cycle; same with sh_c_en=1, sh_c=0 → msr=0100.
- LOAD_BOTH 0010, SWAP after loading msr=1001 via BUS_TO_M → usr=1001, msr=0010; cin_sel=3, cond src 0 → co=0, cin_inv=1 → co=1.
- DEPTH=4: push 5 distinct {MSR,uSR} values → 5th sets err, depth=4, full=1; 4 pops return values in reverse; 5th pop → err stays 1, registers unchanged.
- Sweep all 16 tests × 3 sources with exhaustive flag values → ct matches table; odd codes always complement even.
- PUSH asserted together with clr_err while full → err=1; reset asserted with depth=3 → depth=0 immediately, asynchronously.

Source files
------------

// File: rtl/status_pkg.sv
// Shared types and constants for the micro-BESM status/carry control unit.
// Flag vectors are always ordered {ovr,n,c,z}, bit 3 down to bit 0.
package status_pkg;

  typedef enum logic [3:0] {
    OP_NOP         = 4'd0,
    OP_LOAD_U      = 4'd1,
    OP_LOAD_M      = 4'd2,
    OP_LOAD_BOTH   = 4'd3,
    OP_LOAD_M_CINV = 4'd4,
    OP_LOAD_M_VRET = 4'd5,
    OP_SWAP        = 4'd6,
    OP_M_TO_U      = 4'd7,
    OP_BUS_TO_M    = 4'd8,
    OP_SET_M       = 4'd9,
    OP_CLR_M       = 4'd10,
    OP_INV_M       = 4'd11,
    OP_PUSH        = 4'd12,
    OP_POP         = 4'd13,
    OP_SET_UBIT    = 4'd14,
    OP_CLR_UBIT    = 4'd15
  } op_t;

  typedef logic [3:0] flags_t;

  localparam int F_Z   = 0;
  localparam int F_C   = 1;
  localparam int F_N   = 2;
  localparam int F_OVR = 3;

  localparam logic [1:0] SRC_USR   = 2'd0;
  localparam logic [1:0] SRC_MSR   = 2'd1;
  localparam logic [1:0] SRC_ALU   = 2'd2;
  localparam logic [1:0] SRC_CONST = 2'd3;

  // Only the enabled flag bits take the new value; the rest keep their state.
  function automatic flags_t merge_flags(flags_t cur, flags_t val, flags_t en);
    return (cur & ~en) | (val & en);
  endfunction

endpackage

// File: rtl/status_ctl_if.sv
// Control/flag bundle between the microsequencer side and status_ctl.
// The master drives operations and flags; the slave returns status, ct and co.
interface status_ctl_if #(
  parameter int DEPTH = 4
);
  import status_pkg::*;

  localparam int DW = $clog2(DEPTH + 1);

  op_t          op;
  flags_t       fl_en;
  flags_t       alu_f;
  flags_t       bus_f;
  logic [1:0]   bit_sel;
  logic         sh_c_en;
  logic         sh_c;
  logic [5:0]   cond;
  logic [1:0]   cin_sel;
  logic         cin_inv;
  logic         cx;
  logic         clr_err;

  flags_t       usr;
  flags_t       msr;
  logic         ct;
  logic         co;
  logic [DW-1:0] depth;
  logic         full;
  logic         empty;
  logic         err;

  modport master (
    output op, fl_en, alu_f, bus_f, bit_sel, sh_c_en, sh_c,
           cond, cin_sel, cin_inv, cx, clr_err,
    input  usr, msr, ct, co, depth, full, empty, err
  );

  modport slave (
    input  op, fl_en, alu_f, bus_f, bit_sel, sh_c_en, sh_c,
           cond, cin_sel, cin_inv, cx, clr_err,
    output usr, msr, ct, co, depth, full, empty, err
  );

endinterface

// File: rtl/status_stack.sv
// DEPTH-entry LIFO holding {MSR,uSR} snapshots for interrupt entry/return.
// The top entry is read combinationally so a pop can restore on the same edge.
module status_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [DW-1:0]    depth_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    depth_q;
  logic [DW-1:0]    depth_d;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (depth_q == DW'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign ovf_o   = push_i & full_o;
  assign unf_o   = pop_i & empty_o;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o & ~push_i;

  assign wr_idx  = AW'(depth_q);
  assign rd_idx  = AW'(depth_q - DW'(1));
  assign rdata_o = mem[rd_idx];
  assign depth_o = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + DW'(1);
    end else if (do_pop) begin
      depth_d = depth_q - DW'(1);
    end
  end

  // Reset only clears the occupancy; stale entries are unreachable afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= wdata_i;
    end
  end

endmodule

// File: rtl/status_ctl.sv
// Status-and-carry control: uSR/MSR registers, branch condition test (ct),
// ALU carry-in (co) and the {MSR,uSR} save stack for interrupt entry/return.
module status_ctl
  import status_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  status_ctl_if.slave  sif
);

  localparam int DW = $clog2(DEPTH + 1);

  flags_t        usr_q;
  flags_t        usr_d;
  flags_t        msr_q;
  flags_t        msr_d;
  logic          err_q;
  logic          err_d;

  logic          stk_push;
  logic          stk_pop;
  logic [7:0]    stk_rdata;
  logic [DW-1:0] stk_depth;
  logic          stk_full;
  logic          stk_empty;
  logic          stk_ovf;
  logic          stk_unf;

  flags_t        cond_f;
  logic          ct_base;
  logic          cin_raw;

  assign stk_push = (sif.op == OP_PUSH);
  assign stk_pop  = (sif.op == OP_POP);

  status_stack #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .wdata_i ({msr_q, usr_q}),
    .rdata_o (stk_rdata),
    .depth_o (stk_depth),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .ovf_o   (stk_ovf),
    .unf_o   (stk_unf)
  );

  always_comb begin
    usr_d = usr_q;
    msr_d = msr_q;
    case (sif.op)
      OP_LOAD_U:      usr_d = sif.alu_f;
      OP_LOAD_M:      msr_d = merge_flags(msr_q, sif.alu_f, sif.fl_en);
      OP_LOAD_BOTH: begin
        usr_d = sif.alu_f;
        msr_d = sif.alu_f;
      end
      OP_LOAD_M_CINV: msr_d = merge_flags(msr_q,
                                {sif.alu_f[F_OVR], sif.alu_f[F_N], ~sif.alu_f[F_C], sif.alu_f[F_Z]},
                                sif.fl_en);
      // Overflow accumulates across the return so a lost overflow is not cleared.
      OP_LOAD_M_VRET: msr_d = merge_flags(msr_q,
                                {sif.alu_f[F_OVR] | msr_q[F_OVR], sif.alu_f[F_N],
                                 sif.alu_f[F_C], sif.alu_f[F_Z]},
                                sif.fl_en);
      OP_SWAP: begin
        usr_d = msr_q;
        msr_d = usr_q;
      end
      OP_M_TO_U:      usr_d = msr_q;
      OP_BUS_TO_M:    msr_d = merge_flags(msr_q, sif.bus_f, sif.fl_en);
      OP_SET_M:       msr_d = 4'b1111;
      OP_CLR_M:       msr_d = 4'b0000;
      OP_INV_M:       msr_d = merge_flags(msr_q, ~msr_q, sif.fl_en);
      OP_POP: begin
        if (!stk_empty) begin
          msr_d = stk_rdata[7:4];
          usr_d = stk_rdata[3:0];
        end
      end
      OP_SET_UBIT:    usr_d[sif.bit_sel] = 1'b1;
      OP_CLR_UBIT:    usr_d[sif.bit_sel] = 1'b0;
      default: ;
    endcase
    if (sif.sh_c_en) begin
      msr_d[F_C] = sif.sh_c;
    end
  end

  // A fresh over/underflow wins over a simultaneous clear.
  assign err_d = (sif.clr_err ? 1'b0 : err_q) | stk_ovf | stk_unf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      usr_q <= '0;
      msr_q <= '0;
      err_q <= 1'b0;
    end else begin
      usr_q <= usr_d;
      msr_q <= msr_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    case (sif.cond[5:4])
      SRC_USR: cond_f = usr_q;
      SRC_MSR: cond_f = msr_q;
      default: cond_f = sif.alu_f;
    endcase
  end

  always_comb begin
    case (sif.cond[3:1])
      3'd0:    ct_base = (cond_f[F_N] ^ cond_f[F_OVR]) | cond_f[F_Z];
      3'd1:    ct_base = cond_f[F_N] ^ cond_f[F_OVR];
      3'd2:    ct_base = cond_f[F_Z];
      3'd3:    ct_base = cond_f[F_OVR];
      3'd4:    ct_base = cond_f[F_C] | cond_f[F_Z];
      3'd5:    ct_base = cond_f[F_C];
      3'd6:    ct_base = ~cond_f[F_C] | cond_f[F_Z];
      default: ct_base = cond_f[F_N];
    endcase
  end

  assign sif.ct = (sif.cond[5:4] == SRC_CONST) ? ~sif.cond[0] : (ct_base ^ sif.cond[0]);

  // The carry source follows the condition source: uSR for source 0, MSR otherwise.
  always_comb begin
    case (sif.cin_sel)
      2'd0:    cin_raw = 1'b0;
      2'd1:    cin_raw = 1'b1;
      2'd2:    cin_raw = sif.cx;
      default: cin_raw = (sif.cond[5:4] == SRC_USR) ? usr_q[F_C] : msr_q[F_C];
    endcase
  end

  assign sif.co    = cin_raw ^ sif.cin_inv;
  assign sif.usr   = usr_q;
  assign sif.msr   = msr_q;
  assign sif.err   = err_q;
  assign sif.depth = stk_depth;
  assign sif.full  = stk_full;
  assign sif.empty = stk_empty;

endmodule

// File: tb/tb_status_ctl.sv
// Scoreboard bench for status_ctl: stimulus pushes expectations from a
// behavioural model; a negedge monitor pops and compares every cycle.
module tb_status_ctl;
  import status_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  status_ctl_if #(.DEPTH(DEPTH)) sif ();

  status_ctl #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  typedef struct {
    op_t        op;
    logic [3:0] fl_en;
    logic [3:0] alu_f;
    logic [3:0] bus_f;
    logic [1:0] bit_sel;
    logic       sh_c_en;
    logic       sh_c;
    logic [5:0] cond;
    logic [1:0] cin_sel;
    logic       cin_inv;
    logic       cx;
    logic       clr_err;
  } stim_t;

  typedef struct {
    string      tag;
    logic [3:0] usr;
    logic [3:0] msr;
    int         depth;
    logic       full;
    logic       empty;
    logic       err;
    logic       ct;
    logic       co;
  } exp_t;

  stim_t      st;
  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_txn = 0;

  // Reference state: flag registers as plain nibbles, the stack as a queue.
  logic [3:0] m_usr;
  logic [3:0] m_msr;
  logic       m_err;
  logic [7:0] m_stk[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ref_ct(input logic [5:0] c, input logic [3:0] f);
    logic ovr, n, cy, z, b;
    ovr = f[3]; n = f[2]; cy = f[1]; z = f[0];
    if (c[5:4] == 2'd3) return !c[0];
    case (c[3:1])
      3'd0: b = (n != ovr) || z;
      3'd1: b = (n != ovr);
      3'd2: b = z;
      3'd3: b = ovr;
      3'd4: b = cy || z;
      3'd5: b = cy;
      3'd6: b = !cy || z;
      default: b = n;
    endcase
    return c[0] ? !b : b;
  endfunction

  function automatic logic [3:0] masked(input logic [3:0] old, input logic [3:0] val,
                                        input logic [3:0] en);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = en[i] ? val[i] : old[i];
    return r;
  endfunction

  task automatic idle_stim();
    st.op = OP_NOP; st.fl_en = 4'h0; st.alu_f = 4'h0; st.bus_f = 4'h0;
    st.bit_sel = 2'd0; st.sh_c_en = 1'b0; st.sh_c = 1'b0; st.cond = 6'd0;
    st.cin_sel = 2'd0; st.cin_inv = 1'b0; st.cx = 1'b0; st.clr_err = 1'b0;
  endtask

  task automatic apply_stim();
    sif.op = st.op; sif.fl_en = st.fl_en; sif.alu_f = st.alu_f; sif.bus_f = st.bus_f;
    sif.bit_sel = st.bit_sel; sif.sh_c_en = st.sh_c_en; sif.sh_c = st.sh_c;
    sif.cond = st.cond; sif.cin_sel = st.cin_sel; sif.cin_inv = st.cin_inv;
    sif.cx = st.cx; sif.clr_err = st.clr_err;
  endtask

  task automatic model_reset();
    m_usr = 4'h0; m_msr = 4'h0; m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_step();
    logic [3:0] nu, nm;
    logic [7:0] top;
    logic       bad;
    nu = m_usr; nm = m_msr; bad = 1'b0;
    case (st.op)
      OP_LOAD_U:      nu = st.alu_f;
      OP_LOAD_M:      nm = masked(m_msr, st.alu_f, st.fl_en);
      OP_LOAD_BOTH:   begin nu = st.alu_f; nm = st.alu_f; end
      OP_LOAD_M_CINV: nm = masked(m_msr, st.alu_f ^ 4'b0010, st.fl_en);
      OP_LOAD_M_VRET: nm = masked(m_msr, {st.alu_f[3] | m_msr[3], st.alu_f[2:0]}, st.fl_en);
      OP_SWAP:        begin nu = m_msr; nm = m_usr; end
      OP_M_TO_U:      nu = m_msr;
      OP_BUS_TO_M:    nm = masked(m_msr, st.bus_f, st.fl_en);
      OP_SET_M:       nm = 4'hF;
      OP_CLR_M:       nm = 4'h0;
      OP_INV_M:       nm = masked(m_msr, ~m_msr, st.fl_en);
      OP_PUSH: begin
        if (m_stk.size() == DEPTH) bad = 1'b1;
        else m_stk.push_back({m_msr, m_usr});
      end
      OP_POP: begin
        if (m_stk.size() == 0) bad = 1'b1;
        else begin
          top = m_stk.pop_back();
          nm = top[7:4]; nu = top[3:0];
        end
      end
      OP_SET_UBIT:    nu[st.bit_sel] = 1'b1;
      OP_CLR_UBIT:    nu[st.bit_sel] = 1'b0;
      default: ;
    endcase
    if (st.sh_c_en) nm[1] = st.sh_c;
    if (bad) m_err = 1'b1;
    else if (st.clr_err) m_err = 1'b0;
    m_usr = nu; m_msr = nm;
  endtask

  // One transaction: apply inputs after an edge, expect current state + comb outputs.
  task automatic issue(input string tag);
    exp_t       e;
    logic [3:0] srcf;
    logic       cr;
    @(posedge clk);
    #1;
    apply_stim();
    case (st.cond[5:4])
      2'd0: srcf = m_usr;
      2'd1: srcf = m_msr;
      default: srcf = st.alu_f;
    endcase
    case (st.cin_sel)
      2'd0: cr = 1'b0;
      2'd1: cr = 1'b1;
      2'd2: cr = st.cx;
      default: cr = (st.cond[5:4] == 2'd0) ? m_usr[1] : m_msr[1];
    endcase
    e.tag = tag; e.usr = m_usr; e.msr = m_msr; e.depth = m_stk.size();
    e.full = (m_stk.size() == DEPTH); e.empty = (m_stk.size() == 0); e.err = m_err;
    e.ct = ref_ct(st.cond, srcf); e.co = cr ^ st.cin_inv;
    sb.push_back(e);
    model_step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_txn++;
        $display("[TB] txn %0d %s usr=%h msr=%h depth=%0d err=%b ct=%b co=%b",
                 n_txn, e.tag, sif.usr, sif.msr, sif.depth, sif.err, sif.ct, sif.co);
        chk({e.tag, ".usr"},   8'(sif.usr),   8'(e.usr));
        chk({e.tag, ".msr"},   8'(sif.msr),   8'(e.msr));
        chk({e.tag, ".depth"}, 8'(sif.depth), 8'(e.depth));
        chk({e.tag, ".full"},  8'(sif.full),  8'(e.full));
        chk({e.tag, ".empty"}, 8'(sif.empty), 8'(e.empty));
        chk({e.tag, ".err"},   8'(sif.err),   8'(e.err));
        chk({e.tag, ".ct"},    8'(sif.ct),    8'(e.ct));
        chk({e.tag, ".co"},    8'(sif.co),    8'(e.co));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    idle_stim();
    apply_stim();
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.usr", 8'(sif.usr), 8'h0);
    chk("rst.msr", 8'(sif.msr), 8'h0);
    chk("rst.depth", 8'(sif.depth), 8'h0);
    chk("rst.empty", 8'(sif.empty), 8'h1);
    chk("rst.full", 8'(sif.full), 8'h0);
    chk("rst.err", 8'(sif.err), 8'h0);
    reset = 1'b0;

    st.cond = 6'b01_0101;
    issue("idle"); issue("idle");
    #1 chk("idle.ct_nmz", 8'(sif.ct), 8'h1);

    idle_stim(); st.op = OP_BUS_TO_M; st.bus_f = 4'b0101; st.fl_en = 4'hF; issue("bus_m");
    idle_stim(); st.op = OP_LOAD_M; st.alu_f = 4'b1010; st.fl_en = 4'b0011; issue("load_m");
    idle_stim(); issue("nop");
    #1 chk("load_m.mask", 8'(sif.msr), 8'b0110);
    idle_stim(); st.op = OP_BUS_TO_M; st.bus_f = 4'b0101; st.fl_en = 4'hF; issue("bus_m");
    idle_stim(); st.op = OP_LOAD_M; st.alu_f = 4'b1010; st.fl_en = 4'b0011;
    st.sh_c_en = 1'b1; st.sh_c = 1'b0; issue("load_m_shc");
    idle_stim(); issue("nop");
    #1 chk("load_m.shc", 8'(sif.msr), 8'b0100);

    idle_stim(); st.op = OP_LOAD_BOTH; st.alu_f = 4'b0010; issue("load_both");
    idle_stim(); st.op = OP_BUS_TO_M; st.bus_f = 4'b1001; st.fl_en = 4'hF; issue("bus_m");
    idle_stim(); st.op = OP_SWAP; issue("swap");
    idle_stim(); st.cin_sel = 2'd3; st.cond = 6'b00_0000; issue("co_usr");
    #1 chk("swap.usr", 8'(sif.usr), 8'b1001);
    chk("swap.msr", 8'(sif.msr), 8'b0010);
    chk("co.usr_c", 8'(sif.co), 8'h0);
    st.cin_inv = 1'b1; issue("co_inv");
    #1 chk("co.inv", 8'(sif.co), 8'h1);

    // Fill the stack past capacity, then drain it past empty.
    for (int i = 0; i < 5; i++) begin
      idle_stim(); st.op = OP_LOAD_U; st.alu_f = 4'(i * 3 + 1); issue("ld_u");
      idle_stim(); st.op = OP_BUS_TO_M; st.bus_f = 4'(15 - i); st.fl_en = 4'hF; issue("bus_m");
      idle_stim(); st.op = OP_PUSH; issue("push");
    end
    idle_stim(); issue("nop");
    #1 chk("ovf.err", 8'(sif.err), 8'h1);
    chk("ovf.depth", 8'(sif.depth), 8'd4);
    chk("ovf.full", 8'(sif.full), 8'h1);
    idle_stim(); st.op = OP_POP; issue("pop");
    idle_stim(); issue("nop");
    #1 chk("pop1.usr", 8'(sif.usr), 8'd10);
    chk("pop1.msr", 8'(sif.msr), 8'd12);
    for (int i = 0; i < 3; i++) begin
      idle_stim(); st.op = OP_POP; issue("pop");
    end
    idle_stim(); st.op = OP_POP; issue("pop_empty");
    idle_stim(); issue("nop");
    #1 chk("unf.usr", 8'(sif.usr), 8'd1);
    chk("unf.msr", 8'(sif.msr), 8'd15);
    chk("unf.err", 8'(sif.err), 8'h1);
    chk("unf.empty", 8'(sif.empty), 8'h1);

    idle_stim(); st.clr_err = 1'b1; issue("clr_err");
    for (int i = 0; i < 4; i++) begin
      idle_stim(); st.op = OP_PUSH; issue("push");
    end
    idle_stim(); st.op = OP_PUSH; st.clr_err = 1'b1; issue("push_clr");
    idle_stim(); issue("nop");
    #1 chk("push_clr.err", 8'(sif.err), 8'h1);

    // ct sweep: every flag pattern in every register source and every test code.
    for (int v = 0; v < 16; v++) begin
      idle_stim(); st.op = OP_LOAD_BOTH; st.alu_f = 4'(v); issue("sweep_ld");
      for (int c = 0; c < 64; c++) begin
        idle_stim(); st.alu_f = 4'(v); st.cond = 6'(c);
        st.cin_sel = 2'($urandom_range(0, 3)); st.cin_inv = 1'($urandom); st.cx = 1'($urandom);
        issue("sweep");
      end
    end

    for (int k = 0; k < 600; k++) begin
      st.op = op_t'($urandom_range(0, 15));
      st.fl_en = 4'($urandom); st.alu_f = 4'($urandom); st.bus_f = 4'($urandom);
      st.bit_sel = 2'($urandom); st.sh_c_en = ($urandom_range(0, 3) == 0);
      st.sh_c = 1'($urandom); st.cond = 6'($urandom); st.cin_sel = 2'($urandom);
      st.cin_inv = 1'($urandom); st.cx = 1'($urandom);
      st.clr_err = ($urandom_range(0, 7) == 0);
      issue("rand");
    end

    // Asynchronous reset with three entries on the stack.
    while (m_stk.size() > 0) begin
      idle_stim(); st.op = OP_POP; issue("pop");
    end
    for (int i = 0; i < 3; i++) begin
      idle_stim(); st.op = OP_SET_UBIT; st.bit_sel = 2'(i); issue("set_ubit");
      idle_stim(); st.op = OP_PUSH; issue("push");
    end
    idle_stim(); issue("nop");
    @(negedge clk);
    #1 chk("pre_rst.depth", 8'(sif.depth), 8'd3);
    reset = 1'b1;
    #1 chk("arst.depth", 8'(sif.depth), 8'd0);
    chk("arst.empty", 8'(sif.empty), 8'h1);
    chk("arst.usr", 8'(sif.usr), 8'h0);
    chk("arst.msr", 8'(sif.msr), 8'h0);
    chk("arst.err", 8'(sif.err), 8'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle_stim(); st.op = OP_POP; issue("pop_after_rst");
    idle_stim(); issue("nop");

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
